// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default stability window and synchronizer depth.
// Latency: n/a (declarations only). Backpressure: n/a.
package btn_pkg;

  // Debounce FSM states; WAIT_* states count stable cycles before committing.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  // 20 ms of stability at a 12 MHz clock.
  localparam int CNT_MAX_DEFAULT = 240000;

  // Number of flops between the raw pin and the FSM.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: 1-bit flop-chain synchronizer for an input asynchronous to clk.
// Latency: SYNC_DEPTH (2) cycles from d to q.
// Backpressure: none; samples every cycle, reset drives the chain to RST_VAL.
module sync_2ff
  import btn_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] chain;

  // Shift the raw input through the chain; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/button_debouncer.sv
// Purpose: debounce an active-low push button into a level plus edge pulses.
// Latency: exactly 2 + CNT_MAX cycles from a clean pin edge to btn_level.
// Backpressure: none. Optional macro BTN_EDGE_PULSE_EN enables btn_rise/btn_fall.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT,
  parameter int CW      = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  // Last count value of a stability window; reaching it commits the change.
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          btn_sync;
  logic          sync_pressed;
  btn_state_t    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          next_level;

  // Pin idles high (released), so the chain resets to 1.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_n),
    .q  (btn_sync)
  );

  assign sync_pressed = ~btn_sync;

  // State, stability counter and registered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RELEASED;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      btn_level <= next_level;
    end
  end

  // Next-state logic: any reversal in a WAIT state falls back and drops the count.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      RELEASED: begin
        if (sync_pressed) begin
          next_state = WAIT_PRESS;
          next_cnt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_pressed) begin
          next_state = RELEASED;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = PRESSED;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_pressed) begin
          next_state = WAIT_RELEASE;
          next_cnt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync_pressed) begin
          next_state = PRESSED;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = RELEASED;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: begin
        next_state = RELEASED;
        next_cnt   = '0;
      end
    endcase
    next_level = (next_state == PRESSED) || (next_state == WAIT_RELEASE);
  end

`ifdef BTN_EDGE_PULSE_EN
  // Pulses are registered alongside btn_level so they line up with its change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      btn_rise <= next_level & ~btn_level;
      btn_fall <= ~next_level & btn_level;
    end
  end
`else
  assign btn_rise = 1'b0;
  assign btn_fall = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with CNT_MAX=4 (latency 6 cycles).
// Cycle k=0 is the first rising edge that samples a new pin value.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_n;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int checks = 0;
  int errors = 0;

`ifdef BTN_EDGE_PULSE_EN
  localparam bit PULSES = 1'b1;
`else
  localparam bit PULSES = 1'b0;
`endif

  button_debouncer #(
    .CNT_MAX(4),
    .CW     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic rise, input logic fall);
    check({tag, ".level"}, btn_level, lvl);
    check({tag, ".rise"}, btn_rise, rise);
    check({tag, ".fall"}, btn_fall, fall);
  endtask

  // Step n cycles after a clean pin edge; the level flips at cycle 'at'.
  task automatic edge_run(input string tag, input int n, input int at, input bit rising);
    logic lvl;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      lvl = rising ? (k >= at) : (k < at);
      check_outs($sformatf("%s[%0d]", tag, k), lvl,
                 PULSES & rising & (k == at), PULSES & ~rising & (k == at));
    end
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;

    // Outputs held at zero while reset is active.
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle button: nothing happens.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("idle[%0d]", k), 1'b0, 1'b0, 1'b0);
    end

    // Clean press, then held long: exactly one rise at cycle 6.
    btn_n = 1'b0;
    edge_run("press", 30, 6, 1'b1);

    // Clean release: fall at cycle 6.
    btn_n = 1'b1;
    edge_run("release", 12, 6, 1'b0);

    // Bounce: low for three samples then high; never accepted.
    btn_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("bounce[%0d]", k), 1'b0, 1'b0, 1'b0);
      if (k == 2) btn_n = 1'b1;
    end

    // Final fall of the pin after the bounce: rise 6 cycles later.
    btn_n = 1'b0;
    edge_run("settle", 12, 6, 1'b1);
    btn_n = 1'b1;
    edge_run("settle_rel", 12, 6, 1'b0);

    // Reset two cycles into WAIT_PRESS with the button held.
    btn_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("midrst[%0d]", k), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    edge_run("post_rst", 12, 6, 1'b1);

    btn_n = 1'b1;
    edge_run("final_rel", 10, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time in case the sequence above ever stalls.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no completion, required completion by 100000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
